// File: rtl/sevenseg_scan_if.sv
// Display-side bundle for sevenseg_scan_ctrl: scan control, display data and
// the multiplexed digit outputs. The controller connects through the slave
// modport and the host/bench through the master modport.
interface sevenseg_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      en;
   logic                      load;
   logic [3*NUM_DIGITS-1:0]   value;
   logic [NUM_DIGITS-1:0]     blank_mask;
   logic [2:0]                oct_code;
   logic [NUM_DIGITS-1:0]     digit_sel;
   logic                      frame_done;

   modport master (
      output en, load, value, blank_mask,
      input  oct_code, digit_sel, frame_done
   );

   modport slave (
      input  en, load, value, blank_mask,
      output oct_code, digit_sel, frame_done
   );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Octal seven-segment scan controller. Time-multiplexes NUM_DIGITS octal
// digits onto one shared decoder, with a blanking gap between digits and
// double-buffered display data that only changes at frame boundaries.
// Optional macro SEVENSEG_LZ_SUPPRESS_EN enables leading-zero suppression.
module sevenseg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 50000,
   parameter int BLANK_CYC  = 16
) (
   input  logic           clk,
   input  logic           reset,
   sevenseg_scan_if.slave bus
);

   localparam int DW      = 3 * NUM_DIGITS;
   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int CNT_MAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      BLANK
   } state_t;

   state_t                  state;
   logic [IDX_W-1:0]        idx;
   logic [CNT_W-1:0]        cnt;
   logic [DW-1:0]           shadow;
   logic [DW-1:0]           pending;
   logic                    pend_valid;
   logic [2:0]              oct_code_q;
   logic [NUM_DIGITS-1:0]   digit_sel_q;
   logic                    frame_done_q;

   logic [DW-1:0]           xfer_shadow;
   logic [IDX_W-1:0]        idx_inc;
   logic [NUM_DIGITS-1:0]   hide_cur;
   logic [NUM_DIGITS-1:0]   hide_nxt;

   // Octal digit k of a packed display word.
   function automatic logic [2:0] digit_of(input logic [DW-1:0] sh,
                                           input logic [IDX_W-1:0] k);
      return sh[3*int'(k) +: 3];
   endfunction

   // Active-low select for digit k, or all-off when k is hidden.
   function automatic logic [NUM_DIGITS-1:0] sel_for(input logic [NUM_DIGITS-1:0] hide,
                                                     input logic [IDX_W-1:0] k);
      logic [NUM_DIGITS-1:0] sel;
      sel = '1;
      if (!hide[k]) sel[k] = 1'b0;
      return sel;
   endfunction

`ifdef SEVENSEG_LZ_SUPPRESS_EN
   // Digit k (k>0) is a leading zero when digits k..NUM_DIGITS-1 are all zero.
   function automatic logic [NUM_DIGITS-1:0] lz_hide(input logic [DW-1:0] sh);
      logic [NUM_DIGITS-1:0] h;
      logic                  any_nz;
      h      = '0;
      any_nz = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         any_nz = any_nz | (sh[3*k +: 3] != 3'd0);
         if (k != 0) h[k] = ~any_nz;
      end
      return h;
   endfunction

   assign hide_cur = bus.blank_mask | lz_hide(shadow);
   assign hide_nxt = bus.blank_mask | lz_hide(xfer_shadow);
`else
   assign hide_cur = bus.blank_mask;
   assign hide_nxt = bus.blank_mask;
`endif

   // Value the shadow takes on a frame boundary or in IDLE: a load in that
   // very cycle wins over an older pending value.
   assign xfer_shadow = bus.load ? bus.value : (pend_valid ? pending : shadow);
   assign idx_inc     = (idx == IDX_LAST) ? '0 : idx + 1'b1;

   // Scan sequencer with registered digit outputs and the double buffer.
   // NOTE: reset is synchronous and also clears the display buffers, so every
   // register here lives in one edge-triggered block using non-blocking updates.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         idx          <= '0;
         cnt          <= '0;
         shadow       <= '0;
         pending      <= '0;
         pend_valid   <= 1'b0;
         oct_code_q   <= 3'd0;
         digit_sel_q  <= '1;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (bus.load) begin
            pending    <= bus.value;
            pend_valid <= 1'b1;
         end
         if (!bus.en) begin
            if (state == IDLE) begin
               shadow     <= xfer_shadow;
               pend_valid <= 1'b0;
            end
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            digit_sel_q <= '1;
         end else begin
            unique case (state)
               IDLE: begin
                  shadow       <= xfer_shadow;
                  pend_valid   <= 1'b0;
                  state        <= SHOW;
                  idx          <= '0;
                  cnt          <= '0;
                  frame_done_q <= 1'b1;
                  oct_code_q   <= digit_of(xfer_shadow, '0);
                  digit_sel_q  <= sel_for(hide_nxt, '0);
               end
               SHOW: begin
                  if (cnt == SHOW_LAST) begin
                     state       <= BLANK;
                     cnt         <= '0;
                     digit_sel_q <= '1;
                  end else begin
                     cnt         <= cnt + 1'b1;
                     digit_sel_q <= sel_for(hide_cur, idx);
                  end
               end
               BLANK: begin
                  if (cnt == BLANK_LAST) begin
                     state <= SHOW;
                     cnt   <= '0;
                     idx   <= idx_inc;
                     if (idx == IDX_LAST) begin
                        shadow       <= xfer_shadow;
                        pend_valid   <= 1'b0;
                        frame_done_q <= 1'b1;
                        oct_code_q   <= digit_of(xfer_shadow, '0);
                        digit_sel_q  <= sel_for(hide_nxt, '0);
                     end else begin
                        oct_code_q  <= digit_of(shadow, idx_inc);
                        digit_sel_q <= sel_for(hide_cur, idx_inc);
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.oct_code   = oct_code_q;
   assign bus.digit_sel  = digit_sel_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl (NUM_DIGITS=4, PRESCALE=4,
// BLANK_CYC=2). Expected outputs come from a timeline model: position in the
// frame decides slot and SHOW/BLANK phase; display data follows the
// double-buffer rules. Directed steps first, then randomized traffic.
module tb_sevenseg_scan_ctrl;

   localparam int N     = 4;
   localparam int P     = 4;
   localparam int B     = 2;
   localparam int SLOT  = P + B;
   localparam int FRAME = N * SLOT;

   logic clk = 1'b0;
   logic reset;

   sevenseg_scan_if #(.NUM_DIGITS(N)) bus ();

   sevenseg_scan_ctrl #(
      .NUM_DIGITS (N),
      .PRESCALE   (P),
      .BLANK_CYC  (B)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int last_fd     = -1;

   // reference model state
   bit          m_active = 1'b0;
   int          m_t      = 0;
   logic [11:0] m_shadow = '0;
   logic [11:0] m_pending = '0;
   bit          m_pv     = 1'b0;
   logic [3:0]  m_sel    = 4'hF;
   logic [2:0]  m_code   = 3'd0;
   logic        m_fd     = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit visible(input int slot);
      bit v;
      v = !bus.blank_mask[slot];
`ifdef SEVENSEG_LZ_SUPPRESS_EN
      if (slot != 0 && (m_shadow >> (3 * slot)) == 12'd0) v = 1'b0;
`endif
      return v;
   endfunction

   // Advance the model across one clock edge using the inputs now applied.
   task automatic model_edge();
      logic [11:0] xfer;
      int slot;
      int off;
      xfer = bus.load ? bus.value : (m_pv ? m_pending : m_shadow);
      if (reset) begin
         m_active  = 1'b0;
         m_shadow  = '0;
         m_pending = '0;
         m_pv      = 1'b0;
         m_sel     = 4'hF;
         m_code    = 3'd0;
         m_fd      = 1'b0;
      end else if (!bus.en) begin
         if (!m_active) begin
            m_shadow = xfer;
            m_pv     = 1'b0;
         end else if (bus.load) begin
            m_pending = bus.value;
            m_pv      = 1'b1;
         end
         m_active = 1'b0;
         m_sel    = 4'hF;
         m_fd     = 1'b0;
      end else begin
         if (!m_active) begin
            m_active = 1'b1;
            m_t      = 0;
         end else begin
            m_t = (m_t + 1) % FRAME;
         end
         if (m_t == 0) begin
            m_shadow = xfer;
            m_pv     = 1'b0;
         end else if (bus.load) begin
            m_pending = bus.value;
            m_pv      = 1'b1;
         end
         m_fd = (m_t == 0);
         slot = m_t / SLOT;
         off  = m_t % SLOT;
         if (off < P) begin
            m_code = m_shadow[3*slot +: 3];
            m_sel  = visible(slot) ? ~(4'b0001 << slot) : 4'hF;
         end else begin
            m_sel = 4'hF;
         end
      end
   endtask

   // One clock: update model, let the edge pass, compare away from the edge.
   task automatic step();
      if (reset || !bus.en) last_fd = -1;
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      check("digit_sel", 32'(bus.digit_sel), 32'(m_sel));
      check("oct_code", 32'(bus.oct_code), 32'(m_code));
      check("frame_done", 32'(bus.frame_done), 32'(m_fd));
      if (bus.frame_done === 1'b1) begin
         if (last_fd >= 0) check("frame_period", 32'(cyc - last_fd), 32'(FRAME));
         last_fd = cyc;
      end
   endtask

   // Step until the model sits at frame position tgt, bounded by two frames.
   task automatic run_until(input int tgt);
      int guard;
      guard = 0;
      while (!(m_active && m_t == tgt) && guard < 2 * FRAME) begin
         step();
         guard++;
      end
      if (!(m_active && m_t == tgt)) begin
         vectors++;
         miscompares++;
         $error("FAIL reach_pos observed=%0d expected=%0d", m_t, tgt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset          = 1'b1;
      bus.en         = 1'b0;
      bus.load       = 1'b0;
      bus.value      = '0;
      bus.blank_mask = '0;

      // reset held for three cycles
      repeat (3) step();
      check("reset_sel", 32'(bus.digit_sel), 32'hF);
      reset = 1'b0;

      // load while idle, then scan two frames: order 4,3,2,1 and timing
      bus.load  = 1'b1;
      bus.value = 12'o1234;
      step();
      bus.load = 1'b0;
      bus.en   = 1'b1;
      repeat (2 * FRAME) step();

      // double buffering: load during digit-1 slot
      run_until(7);
      bus.load  = 1'b1;
      bus.value = 12'o7777;
      step();
      bus.load = 1'b0;
      repeat (FRAME + SLOT) step();

      // masking of digit 2
      bus.blank_mask = 4'b0100;
      repeat (FRAME) step();
      bus.blank_mask = 4'b0000;
      repeat (SLOT) step();

      // disable mid-SHOW, then re-enable
      run_until(13);
      bus.en = 1'b0;
      repeat (2) step();
      bus.en = 1'b1;
      repeat (FRAME) step();

      // collision: pending value overridden by load on the wrap cycle
      run_until(10);
      bus.load  = 1'b1;
      bus.value = 12'o0777;
      step();
      bus.load = 1'b0;
      run_until(FRAME - 1);
      bus.load  = 1'b1;
      bus.value = 12'o0005;
      step();
      bus.load = 1'b0;
      check("pend_valid", 32'(dut.pend_valid), 32'(m_pv));
      check("collision_code", 32'(bus.oct_code), 32'd5);
      repeat (FRAME) step();

      // reset mid-scan
      run_until(2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (FRAME) step();

      // leading-zero patterns (behaviour depends on the build option)
      bus.en = 1'b0;
      step();
      bus.load  = 1'b1;
      bus.value = 12'o0050;
      step();
      bus.load = 1'b0;
      bus.en   = 1'b1;
      repeat (FRAME) step();
      bus.en = 1'b0;
      step();
      bus.load  = 1'b1;
      bus.value = 12'o0000;
      step();
      bus.load = 1'b0;
      bus.en   = 1'b1;
      repeat (FRAME) step();

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         bus.en   = ($urandom_range(0, 19) != 0);
         bus.load = ($urandom_range(0, 9) == 0);
         bus.value = 12'($urandom);
         if ($urandom_range(0, 15) == 0) bus.blank_mask = 4'($urandom);
         reset = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexes NUM_DIGITS octal digits onto one shared 3-bit octal-to-seven-segment decoder and one common segment bus.
- Drives an active-low per-digit select and the 3-bit code to the decoder.
- Inserts a blanking gap between digits to prevent ghosting.
- Uses double-buffered display data so new values take effect only at a frame boundary (no tearing).
- Sits between the processor output register and the display decoder.

Parameters:
- NUM_DIGITS, 4, number of octal digits scanned (2..8).
- PRESCALE, 50000, clock cycles each digit is driven per scan slot (>=1).
- BLANK_CYC, 16, clock cycles all digits are off between slots (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  scan enable; 0 = display dark and idle.
- load  in  1  one-cycle strobe to capture value.
- value  in  3*NUM_DIGITS  octal digits; bits [3k+2:3k] = digit k; digit 0 is least significant.
- blank_mask  in  NUM_DIGITS  1 = digit k is never lit (its slot time is still consumed).
- oct_code  out  3  code for the shared decoder.
- digit_sel  out  NUM_DIGITS  active-low digit enables; at most one bit is 0 at any time.
- frame_done  out  1  one-cycle pulse at the start of each new frame.

Behaviour:
- Reset state:
  - State IDLE, idx=0, prescaler=0.
  - shadow=0, pending=0, pend_valid=0.
  - digit_sel all 1, oct_code=0, frame_done=0.
- Reset asserted mid-scan restores these values on the next edge, overriding all other inputs.
- All outputs are registered.
- Load path:
  - load=1 writes value into pending and sets pend_valid.
  - pending is copied into shadow, and pend_valid cleared, only at a frame boundary or while IDLE.
  - While IDLE, load writes shadow directly.
  - load on a frame-boundary cycle writes shadow directly; that digit-0 slot already shows the new value.
  - Back-to-back loads within a frame: the last one wins.
- State machine:
  - IDLE -> SHOW when en=1. Entered with idx=0 and prescaler=0, and frame_done pulses on that entry.
  - SHOW:
    - digit_sel[idx]=0 unless blank_mask[idx]=1; oct_code = shadow digit idx.
    - Lasts exactly PRESCALE cycles, then -> BLANK with prescaler cleared.
  - BLANK:
    - digit_sel all 1; oct_code holds its last value.
    - Lasts exactly BLANK_CYC cycles, then -> SHOW with idx+1.
  - Index wrap: idx wraps NUM_DIGITS-1 -> 0. That transition is the frame boundary: frame_done=1 for the first SHOW cycle of digit 0, and the pending->shadow transfer lands in the same cycle.
  - en=0 in any state -> IDLE on the next edge: digit_sel all 1, idx=0, prescaler=0, and shadow is retained.
- Timing:
  - Slot period = PRESCALE+BLANK_CYC cycles.
  - Frame period = NUM_DIGITS*(PRESCALE+BLANK_CYC) cycles.
- blank_mask is sampled combinationally in the cycle it applies. A change takes effect in the next cycle without disturbing the sequence.
- Never more than one digit_sel bit low; there is never a cycle with two digits lit across the SHOW/BLANK edge.

Optional Feature:
- Macro: SEVENSEG_LZ_SUPPRESS_EN.
- When defined:
  - Leading-zero suppression: digit k is additionally blanked when shadow digits k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - Suppression is evaluated on shadow, so it changes only at frame boundaries.
  - Slot timing is unchanged.
- When undefined: all digits not masked by blank_mask are lit, including leading zeros.

Test Plan:
- Reset and timing (NUM_DIGITS=4, PRESCALE=4, BLANK_CYC=2): reset 3 cycles, then en=1. Required:
  - digit_sel=1111 during reset.
  - digit_sel=1110 for 4 cycles, then 1111 for 2, then 1101.
  - frame_done every 24 cycles.
- Digit order: while IDLE, load value=12'o1234. Required: oct_code in slots 0..3 = 4,3,2,1 with digit_sel 1110,1101,1011,0111.
- Double buffering: load 12'o7777 mid-frame (digit 1 slot) over 12'o1234. Required:
  - Digits 2 and 3 still show 2,1.
  - 7s appear from the digit-0 slot coinciding with the next frame_done.
- Masking and disable:
  - blank_mask=4'b0100: slot 2 keeps digit_sel=1111 for 4 cycles, other slots unchanged.
  - en=0 mid-SHOW: digit_sel=1111 on the next cycle.
  - re-enable: scan restarts at digit 0 with frame_done.
- Collision: load asserted on the wrap cycle with value=12'o0005. Required: oct_code=5 in that same digit-0 slot, and pend_valid=0 afterwards.
- SEVENSEG_LZ_SUPPRESS_EN: value=12'o0050. Required:
  - Digits 3 and 2 are 1111 in their slots; digits 1 and 0 show 5 and 0.
  - value=0: only digit 0 is lit.
